// File: rtl/fccc_lock_supervisor_pkg.sv
// Shared types and helpers for the fabric CCC lock supervisor.
package fccc_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4,
    ST_CFG_SETUP  = 3'd5,
    ST_CFG_ACCESS = 3'd6
  } state_t;

  // Width of the shared sequencing counter: enough to hold the largest cycle parameter.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fccc_lock_supervisor_sync.sv
// Two-flop synchroniser for asynchronous status pins (PLL LOCK and similar).
module fccc_lock_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fccc_lock_supervisor.sv
// Fabric CCC PLL lock supervisor: holds PLL reset, waits for LOCK, debounces it,
// then releases the fabric reset. Retries on timeout, faults after MAX_RETRIES.
// Optional APB reconfiguration path enabled by macro FCCC_APB_RECONFIG_EN.
module fccc_lock_supervisor
  import fccc_sup_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT    = 16384,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       RELOCK_REQ,
`ifdef FCCC_APB_RECONFIG_EN
  input  logic       CFG_REQ,
  input  logic [5:0] CFG_ADDR,
  input  logic [7:0] CFG_DATA,
  output logic       CFG_ACK,
  input  logic       CCC_BUSY,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
`endif
  output logic       PLL_ARST_N,
  output logic       PLL_POWERDOWN_N,
  output logic       FABRIC_RESET_N,
  output logic       LOCKED,
  output logic       LOCK_LOST,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT
);

  localparam int unsigned CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       retry_n;
  logic             lost_n;
  logic             lock_s;
  logic             cfg_active;

  fccc_lock_sync #(.WIDTH(1)) u_lock_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (PLL_LOCK),
    .sync_out (lock_s)
  );

`ifdef FCCC_APB_RECONFIG_EN
  logic cfg_take;
  logic cfg_ack_n;
  assign cfg_active = (state == ST_CFG_SETUP) || (state == ST_CFG_ACCESS);
`else
  assign cfg_active = 1'b0;
`endif

  // Next-state, counter and retry decisions; RELOCK_REQ outranks everything
  // except an APB access already in flight.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = RETRY_CNT;
    lost_n  = 1'b0;
`ifdef FCCC_APB_RECONFIG_EN
    cfg_take  = 1'b0;
    cfg_ack_n = 1'b0;
`endif
    if (RELOCK_REQ && !cfg_active) begin
      state_n = ST_PLL_RST;
      cnt_n   = '0;
      retry_n = '0;
    end
`ifdef FCCC_APB_RECONFIG_EN
    else if (CFG_REQ && (state == ST_RUN || state == ST_FAULT || state == ST_PLL_RST)) begin
      state_n  = ST_CFG_SETUP;
      cnt_n    = '0;
      cfg_take = 1'b1;
    end
`endif
    else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == HOLD_LAST) begin
            state_n = ST_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_n = ST_STABLE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_n = '0;
            if (RETRY_CNT == RETRY_MAX) begin
              state_n = ST_FAULT;
            end else begin
              state_n = ST_PLL_RST;
              retry_n = RETRY_CNT + 4'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_n = ST_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = ST_RUN;
            cnt_n   = '0;
            retry_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_n = ST_PLL_RST;
            cnt_n   = '0;
            lost_n  = 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_n = '0;
        end
`ifdef FCCC_APB_RECONFIG_EN
        ST_CFG_SETUP: begin
          state_n = ST_CFG_ACCESS;
        end
        ST_CFG_ACCESS: begin
          if (!CCC_BUSY) begin
            state_n   = ST_PLL_RST;
            cnt_n     = '0;
            cfg_ack_n = 1'b1;
          end
        end
`endif
        default: begin
          state_n = ST_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State register; every output is decoded from the next state so it is
  // registered and valid on the same edge the state changes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= ST_PLL_RST;
      cnt             <= '0;
      RETRY_CNT       <= '0;
      PLL_ARST_N      <= 1'b0;
      PLL_POWERDOWN_N <= 1'b1;
      FABRIC_RESET_N  <= 1'b0;
      LOCKED          <= 1'b0;
      LOCK_LOST       <= 1'b0;
      FAULT           <= 1'b0;
`ifdef FCCC_APB_RECONFIG_EN
      CFG_ACK <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
`endif
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      RETRY_CNT       <= retry_n;
      PLL_ARST_N      <= (state_n == ST_WAIT_LOCK) || (state_n == ST_STABLE) || (state_n == ST_RUN);
      PLL_POWERDOWN_N <= (state_n != ST_FAULT);
      FABRIC_RESET_N  <= (state_n == ST_RUN);
      LOCKED          <= (state_n == ST_RUN);
      LOCK_LOST       <= lost_n;
      FAULT           <= (state_n == ST_FAULT);
`ifdef FCCC_APB_RECONFIG_EN
      CFG_ACK <= cfg_ack_n;
      PSEL    <= (state_n == ST_CFG_SETUP) || (state_n == ST_CFG_ACCESS);
      PWRITE  <= (state_n == ST_CFG_SETUP) || (state_n == ST_CFG_ACCESS);
      PENABLE <= (state_n == ST_CFG_ACCESS);
      if (cfg_take) begin
        PADDR  <= CFG_ADDR;
        PWDATA <= CFG_DATA;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fccc_lock_supervisor.sv
// Directed bench for fccc_lock_supervisor (LOCK_TIMEOUT shortened to 256).
module tb_fccc_lock_supervisor;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PLL_LOCK = 1'b0;
  logic       RELOCK_REQ = 1'b0;
  logic       PLL_ARST_N, PLL_POWERDOWN_N, FABRIC_RESET_N, LOCKED, LOCK_LOST, FAULT;
  logic [3:0] RETRY_CNT;
`ifdef FCCC_APB_RECONFIG_EN
  logic       CFG_REQ = 1'b0;
  logic [5:0] CFG_ADDR = '0;
  logic [7:0] CFG_DATA = '0;
  logic       CCC_BUSY = 1'b0;
  logic       CFG_ACK, PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
`endif

  int errors = 0;
  int checks = 0;
  int lost_count = 0;
  int lost_base;

  fccc_lock_supervisor #(
    .RST_HOLD_CYCLES (64),
    .LOCK_TIMEOUT    (256),
    .STABLE_CYCLES   (1024),
    .MAX_RETRIES     (3)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PLL_LOCK        (PLL_LOCK),
    .RELOCK_REQ      (RELOCK_REQ),
`ifdef FCCC_APB_RECONFIG_EN
    .CFG_REQ         (CFG_REQ),
    .CFG_ADDR        (CFG_ADDR),
    .CFG_DATA        (CFG_DATA),
    .CFG_ACK         (CFG_ACK),
    .CCC_BUSY        (CCC_BUSY),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
`endif
    .PLL_ARST_N      (PLL_ARST_N),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .LOCKED          (LOCKED),
    .LOCK_LOST       (LOCK_LOST),
    .FAULT           (FAULT),
    .RETRY_CNT       (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  // Counts LOCK_LOST pulses, sampled mid-cycle.
  always @(negedge CLK) if (LOCK_LOST === 1'b1) lost_count++;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arst"}, 32'(PLL_ARST_N), 32'd0);
    check({tag, "_pwrdn"}, 32'(PLL_POWERDOWN_N), 32'd1);
    check({tag, "_frst"}, 32'(FABRIC_RESET_N), 32'd0);
    check({tag, "_locked"}, 32'(LOCKED), 32'd0);
    check({tag, "_lost"}, 32'(LOCK_LOST), 32'd0);
    check({tag, "_fault"}, 32'(FAULT), 32'd0);
    check({tag, "_retry"}, 32'(RETRY_CNT), 32'd0);
  endtask

  initial begin
    // ---- Reset state
    tick(3);
    check_reset_outputs("rst");

    // ---- Test 1: clean lock. Edge n = nth edge after RESET release.
    RESET = 1'b0;
    tick(10);                 // edge 10
    PLL_LOCK = 1'b1;
    tick(53);                 // edge 63: still holding PLL reset
    check("t1_arst_63", 32'(PLL_ARST_N), 32'd0);
    tick(1);                  // edge 64: WAIT_LOCK
    check("t1_arst_64", 32'(PLL_ARST_N), 32'd1);
    tick(1024);               // edge 1088: STABLE count reaching 1023
    check("t1_locked_1088", 32'(LOCKED), 32'd0);
    check("t1_frst_1088", 32'(FABRIC_RESET_N), 32'd0);
    tick(1);                  // edge 1089 = 64 + 1 + 1024: RUN
    check("t1_locked_1089", 32'(LOCKED), 32'd1);
    check("t1_frst_1089", 32'(FABRIC_RESET_N), 32'd1);
    check("t1_retry", 32'(RETRY_CNT), 32'd0);
    check("t1_pwrdn", 32'(PLL_POWERDOWN_N), 32'd1);

    // ---- Test 4: lock loss in RUN. Pin falls after edge R.
    lost_base = lost_count;
    PLL_LOCK = 1'b0;
    tick(2);                  // R+2: synchroniser output just went low
    check("t4_frst_r2", 32'(FABRIC_RESET_N), 32'd1);
    check("t4_locked_r2", 32'(LOCKED), 32'd1);
    tick(1);                  // R+3: RUN -> PLL_RST
    check("t4_lost_r3", 32'(LOCK_LOST), 32'd1);
    check("t4_frst_r3", 32'(FABRIC_RESET_N), 32'd0);
    check("t4_locked_r3", 32'(LOCKED), 32'd0);
    check("t4_arst_r3", 32'(PLL_ARST_N), 32'd0);
    tick(1);                  // R+4
    check("t4_lost_r4", 32'(LOCK_LOST), 32'd0);
    tick(62);                 // R+66: 64th cycle of hold
    check("t4_arst_r66", 32'(PLL_ARST_N), 32'd0);
    check("t4_lost_once", 32'(lost_count - lost_base), 32'd1);
    tick(1);                  // R+67 = W: WAIT_LOCK
    check("t4_arst_r67", 32'(PLL_ARST_N), 32'd1);

    // ---- Test 2: lock never returns; attempt period 256 + 64 = 320.
    tick(255);                // W+255
    check("t2_retry0", 32'(RETRY_CNT), 32'd0);
    tick(1);                  // W+256: first timeout
    check("t2_retry1", 32'(RETRY_CNT), 32'd1);
    check("t2_arst_retry1", 32'(PLL_ARST_N), 32'd0);
    tick(320);                // W+576
    check("t2_retry2", 32'(RETRY_CNT), 32'd2);
    tick(320);                // W+896
    check("t2_retry3", 32'(RETRY_CNT), 32'd3);
    tick(319);                // W+1215
    check("t2_nofault_yet", 32'(FAULT), 32'd0);
    check("t2_arst_waiting", 32'(PLL_ARST_N), 32'd1);
    tick(1);                  // W+1216: fourth timeout -> FAULT
    check("t2_fault", 32'(FAULT), 32'd1);
    check("t2_pwrdn", 32'(PLL_POWERDOWN_N), 32'd0);
    check("t2_arst_fault", 32'(PLL_ARST_N), 32'd0);
    check("t2_retry_fault", 32'(RETRY_CNT), 32'd3);
    tick(5);
    check("t2_fault_sticky", 32'(FAULT), 32'd1);
    RELOCK_REQ = 1'b1;
    tick(1);                  // edge Q: PLL_RST
    RELOCK_REQ = 1'b0;
    check("t2_relock_fault", 32'(FAULT), 32'd0);
    check("t2_relock_retry", 32'(RETRY_CNT), 32'd0);
    check("t2_relock_pwrdn", 32'(PLL_POWERDOWN_N), 32'd1);
    check("t2_relock_arst", 32'(PLL_ARST_N), 32'd0);

    // ---- Test 3: glitch at STABLE count 500.
    // WAIT_LOCK at Q+64, STABLE at Q+65; count 500 set at Q+565 = P+2, so P = Q+563.
    PLL_LOCK = 1'b1;
    tick(563);                // P
    PLL_LOCK = 1'b0;
    tick(1);                  // P+1
    PLL_LOCK = 1'b1;
    tick(2);                  // P+3: FSM sees the low, back to WAIT_LOCK
    check("t3_arst_glitch", 32'(PLL_ARST_N), 32'd1);
    check("t3_locked_glitch", 32'(LOCKED), 32'd0);
    tick(523);                // P+526 = Q+1089: unglitched RUN edge
    check("t3_no_early_run", 32'(LOCKED), 32'd0);
    tick(501);                // P+1027
    check("t3_locked_1027", 32'(LOCKED), 32'd0);
    tick(1);                  // P+1028 = P+4+1024
    check("t3_locked_1028", 32'(LOCKED), 32'd1);
    check("t3_frst_1028", 32'(FABRIC_RESET_N), 32'd1);

    // ---- Test 5a: RELOCK_REQ coincides with lock-loss transition. Pin falls after S.
    lost_base = lost_count;
    PLL_LOCK = 1'b0;
    tick(2);                  // S+2
    RELOCK_REQ = 1'b1;
    tick(1);                  // S+3
    RELOCK_REQ = 1'b0;
    PLL_LOCK = 1'b1;
    check("t5_lost_none", 32'(LOCK_LOST), 32'd0);
    check("t5_frst", 32'(FABRIC_RESET_N), 32'd0);
    check("t5_arst", 32'(PLL_ARST_N), 32'd0);
    tick(3);
    check("t5_lost_count", 32'(lost_count - lost_base), 32'd0);

    // ---- Test 5b: RESET mid-STABLE (STABLE from S+68).
    tick(94);                 // S+100
    check("t5_stable_arst", 32'(PLL_ARST_N), 32'd1);
    RESET = 1'b1;
    tick(1);
    check_reset_outputs("t5_rst");
    RESET = 1'b0;
    tick(63);
    check("t5_rehold_63", 32'(PLL_ARST_N), 32'd0);
    tick(1);
    check("t5_rehold_64", 32'(PLL_ARST_N), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
